// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues sequential word reads to instruction memory and keeps the returned
// words, with their PCs, in an in-order buffer. The decode stage sees the head
// entry already split into its instruction fields. A redirect flushes the
// buffer and marks every outstanding read as one to be dropped on return.
// Optional build macro FETCH_ALIGN_EXC_EN: a misaligned redirect target halts
// fetch and raises fetch_adel until the next aligned redirect.

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  shmat,
  output logic [5:0]  funct,
  output logic [15:0] immediate,
  output logic [25:0] address
`ifdef FETCH_ALIGN_EXC_EN
  ,
  output logic        fetch_adel
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W:0]   OCC_CAP  = (CNT_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
`ifdef FETCH_ALIGN_EXC_EN
    ,
    ST_HALT = 2'd2
`endif
  } state_t;

  state_t            state_r, state_s;
  logic [31:0]       fetch_pc_r;
  logic [31:0]       resp_pc_r;
  logic [CNT_W-1:0]  inflight_r, inflight_nxt_s;
  logic [CNT_W-1:0]  discard_r;
  logic [CNT_W-1:0]  count_r;
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [31:0]       instr_q_r [DEPTH];
  logic [31:0]       pc_q_r    [DEPTH];

  logic [CNT_W:0]    occupancy_s;
  logic              fire_s, keep_s, push_s, pop_s;
  logic [31:0]       redir_pc_s;
  logic [31:0]       head_instr_s;

`ifdef FETCH_ALIGN_EXC_EN
  logic              adel_r;
  logic              misaligned_s;
  assign misaligned_s = (redirect_pc[1:0] != 2'b00);
  assign fetch_adel   = adel_r;
`else
  logic              unused_redirect_low_s;
  assign unused_redirect_low_s = ^redirect_pc[1:0];
`endif

  // Words already buffered plus words still in flight never exceed DEPTH,
  // so every response that is kept always finds a free buffer slot.
  assign occupancy_s  = {1'b0, inflight_r} + {1'b0, count_r};
  assign imem_req     = (state_r == ST_RUN) && (occupancy_s < OCC_CAP) && !redirect_valid;
  assign imem_addr    = fetch_pc_r;
  assign fire_s       = imem_req && imem_gnt;
  assign keep_s       = imem_rvalid && (discard_r == CNT_ZERO);
  assign push_s       = keep_s && !redirect_valid;
  assign pop_s        = out_valid && out_ready && !redirect_valid;
  assign redir_pc_s   = {redirect_pc[31:2], 2'b00};

  assign out_valid    = (count_r != CNT_ZERO);
  assign head_instr_s = instr_q_r[rd_ptr_r];
  assign pc           = pc_q_r[rd_ptr_r];
  assign pc_plus_4    = pc + 32'd4;
  assign opcode       = head_instr_s[31:26];
  assign rs           = head_instr_s[25:21];
  assign rt           = head_instr_s[20:16];
  assign rd           = head_instr_s[15:11];
  assign shmat        = {1'b0, head_instr_s[10:6]};
  assign funct        = head_instr_s[5:0];
  assign immediate    = head_instr_s[15:0];
  assign address      = head_instr_s[25:0];

  // Outstanding-read count after this cycle's grant and response.
  always_comb begin
    inflight_nxt_s = inflight_r;
    if (fire_s && !imem_rvalid) begin
      inflight_nxt_s = inflight_r + CNT_ONE;
    end else if (!fire_s && imem_rvalid) begin
      inflight_nxt_s = inflight_r - CNT_ONE;
    end else begin
      inflight_nxt_s = inflight_r;
    end
  end

  // Next-state logic: leave BOOT after one cycle; a redirect picks RUN or HALT.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: state_s = ST_RUN;
      ST_RUN:  state_s = ST_RUN;
`ifdef FETCH_ALIGN_EXC_EN
      ST_HALT: state_s = ST_HALT;
`endif
      default: state_s = ST_BOOT;
    endcase
`ifdef FETCH_ALIGN_EXC_EN
    if (redirect_valid) begin
      state_s = misaligned_s ? ST_HALT : ST_RUN;
    end else begin
      state_s = state_s;
    end
`endif
  end

  // State register (and the alignment fault flag when that build is selected).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
`ifdef FETCH_ALIGN_EXC_EN
      adel_r  <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
`ifdef FETCH_ALIGN_EXC_EN
      if (redirect_valid) begin
        adel_r <= misaligned_s;
      end
`endif
    end
  end

  // Fetch address, response PC tracking and outstanding/drop counters.
  // On a redirect every read still outstanding belongs to the old stream,
  // so the drop counter becomes the post-update in-flight count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= CNT_ZERO;
      discard_r  <= CNT_ZERO;
    end else begin
      inflight_r <= inflight_nxt_s;
      if (redirect_valid) begin
        fetch_pc_r <= redir_pc_s;
        resp_pc_r  <= redir_pc_s;
        discard_r  <= inflight_nxt_s;
      end else begin
        if (fire_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end
        if (push_s) begin
          resp_pc_r <= resp_pc_r + 32'd4;
        end
        if (imem_rvalid && (discard_r != CNT_ZERO)) begin
          discard_r <= discard_r - CNT_ONE;
        end
      end
    end
  end

  // Buffer occupancy and pointers; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r  <= CNT_ZERO;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (redirect_valid) begin
      count_r  <= CNT_ZERO;
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage: instruction word and its PC, written at the tail.
  always_ff @(posedge clk) begin
    if (push_s) begin
      instr_q_r[wr_ptr_r] <= imem_rdata;
      pc_q_r[wr_ptr_r]    <= resp_pc_r;
    end
  end

  fetch_unit_checker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) u_checker (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_s),
    .pop     (pop_s),
    .count   (count_r)
  );

endmodule

// Checks that a kept response never lands in a full buffer.
module fetch_unit_checker #(
  parameter int CNT_W = 3,
  parameter int DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic             push,
  input logic             pop,
  input logic [CNT_W-1:0] count
);

  // Overflow check, sampled on every active clock edge outside reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && !pop && (count == CNT_W'(DEPTH))))
        else $error("fetch_unit: response arrived with the buffer full");
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with optional response
// hold, linear stimulus sequence with hand-computed expectations.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  shmat;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] address;
`ifdef FETCH_ALIGN_EXC_EN
  logic        fetch_adel;
`endif

  int total = 0;
  int bad   = 0;
  int gnt_count = 0;
  logic hold = 1'b0;
  logic [31:0] q [$];

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pc             (pc),
    .pc_plus_4      (pc_plus_4),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .shmat          (shmat),
    .funct          (funct),
    .immediate      (immediate),
    .address        (address)
`ifdef FETCH_ALIGN_EXC_EN
    ,
    .fetch_adel     (fetch_adel)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_3004) return 32'h2408_0005;
    else if (a == 32'h0000_3000) return 32'h0000_0000;
    else return {16'hABCD, a[15:0]};
  endfunction

  // In-order memory: grant sampled at negedge, data returned one cycle later
  // unless hold is set.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && imem_gnt) begin
        q.push_back(imem_addr);
        gnt_count++;
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        q.delete();
        imem_rvalid = 1'b0;
      end else if (!hold && q.size() > 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(q.pop_front());
      end else begin
        imem_rvalid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  initial begin
    rst_n = 1'b0; imem_gnt = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_req", imem_req, 32'd0);
    chk("rst_valid", out_valid, 32'd0);
    rst_n = 1'b1; #1;
    chk("boot_req", imem_req, 32'd0);

    // first requests and first delivered words
    tick();
    chk("first_req", imem_req, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);
    tick();
    chk("second_addr", imem_addr, 32'h0000_3004);
    chk("no_data_yet", out_valid, 32'd0);
    tick();
    chk("w0_valid", out_valid, 32'd1);
    chk("w0_pc", pc, 32'h0000_3000);
    chk("w0_opcode", opcode, 32'd0);

    // stall: exactly DEPTH grants then requests stop
    repeat (6) tick();
    chk("full_req", imem_req, 32'd0);
    chk("full_grants", gnt_count, 32'd4);
    chk("full_addr", imem_addr, 32'h0000_3010);
    chk("full_head", pc, 32'h0000_3000);
    out_ready = 1'b1;
    tick();
    chk("w1_pc", pc, 32'h0000_3004);
    chk("w1_pc4", pc_plus_4, 32'h0000_3008);
    chk("w1_opcode", opcode, 32'h09);
    chk("w1_rs", rs, 32'd0);
    chk("w1_rt", rt, 32'd8);
    chk("w1_imm", immediate, 32'h0005);
    chk("resume_req", imem_req, 32'd1);
    chk("resume_addr", imem_addr, 32'h0000_3010);
    imem_gnt = 1'b0;
    tick();
    chk("w2_pc", pc, 32'h0000_3008);
    repeat (3) tick();
    chk("drained", out_valid, 32'd0);

    // redirect with two reads in flight
    hold = 1'b1; imem_gnt = 1'b1; out_ready = 1'b0;
    repeat (2) tick();
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0000; #1;
    chk("redir_req_gated", imem_req, 32'd0);
    tick();
    redirect_valid = 1'b0; hold = 1'b0; imem_gnt = 1'b1; #1;
    chk("redir_flush", out_valid, 32'd0);
    chk("redir_req", imem_req, 32'd1);
    chk("redir_addr", imem_addr, 32'h0040_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("redir_empty", out_valid, 32'd0);
    end
    tick();
    chk("redir_valid", out_valid, 32'd1);
    chk("redir_pc", pc, 32'h0040_0000);
    chk("redir_opcode", opcode, 32'h2A);

    // redirect coinciding with a response and a non-empty buffer
    redirect_valid = 1'b1; redirect_pc = 32'h0000_5000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("r2_flush", out_valid, 32'd0);
    chk("r2_addr", imem_addr, 32'h0000_5000);
    tick();
    chk("r2_empty_a", out_valid, 32'd0);
    tick();
    chk("r2_empty_b", out_valid, 32'd0);
    tick();
    chk("r2_valid", out_valid, 32'd1);
    chk("r2_pc", pc, 32'h0000_5000);
    chk("r2_imm", immediate, 32'h5000);
    chk("r2_rd", rd, 32'd10);

    // asynchronous reset with three buffered entries
    repeat (2) tick();
    chk("pre_rst_pc", pc, 32'h0000_5000);
    rst_n = 1'b0; #1;
    chk("arst_valid", out_valid, 32'd0);
    chk("arst_req", imem_req, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerun_req", imem_req, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0000_3000);
    chk("rerun_valid", out_valid, 32'd0);

    // misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
    tick();
    redirect_valid = 1'b0; #1;
`ifdef FETCH_ALIGN_EXC_EN
    chk("adel_set", fetch_adel, 32'd1);
    chk("halt_req", imem_req, 32'd0);
    tick();
    chk("halt_req_hold", imem_req, 32'd0);
    chk("adel_hold", fetch_adel, 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    tick();
    redirect_valid = 1'b0; #1;
    chk("adel_clr", fetch_adel, 32'd0);
    chk("align_req", imem_req, 32'd1);
    chk("align_addr", imem_addr, 32'h0000_1000);
    repeat (2) tick();
`else
    chk("align_req", imem_req, 32'd1);
    chk("align_addr", imem_addr, 32'h0000_1000);
    tick();
    chk("align_next", imem_addr, 32'h0000_1004);
    tick();
`endif
    chk("align_valid", out_valid, 32'd1);
    chk("align_pc", pc, 32'h0000_1000);

    // drain, then check fetch address wrap and pc_plus_4 wrap
    imem_gnt = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("wrap_empty", out_valid, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_gnt = 1'b1; out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0; #1;
    chk("wrap_req", imem_req, 32'd1);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    tick();
    chk("wrap_valid", out_valid, 32'd1);
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus_4, 32'h0000_0000);
    chk("wrap_rs", rs, 32'd30);
    chk("wrap_rt", rt, 32'd13);
    chk("wrap_rd", rd, 32'd31);
    chk("wrap_shmat", shmat, 32'h1F);
    chk("wrap_funct", funct, 32'h3C);
    chk("wrap_address", address, 32'h03CD_FFFC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
